// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sharing of one WIDTH-bit up-counter among NREQ
// requesters. A granted owner gets a counting run from 0 to its sampled length,
// then receives a done pulse, or an abort pulse if it drops its request first.
//
// Handshake: a requester raises req_i[k] and holds it as a level. grant_o[k]
// rises one cycle after the request is seen in IDLE. The request must stay high
// until done_o[k] or abort_o[k] pulses. Dropping it while granted aborts the run.
// len_i[k] is sampled only on the grant edge.
module counter_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] len_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [IDX_W-1:0]      owner_o,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      cnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic [NREQ-1:0]       abort_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   abort_q, abort_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q, last_d;

  logic [WIDTH-1:0]  len_arr [NREQ];
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              owner_req;
  logic              run_end;
  logic [NREQ-1:0]   owner_onehot;
  logic [NREQ-1:0]   win_onehot;

  // Split the flat length bus into one slice per requester.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      len_arr[k] = len_i[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first set request starting just after the last winner.
  // The index add wraps naturally because NREQ == 2**IDX_W.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last_q + IDX_W'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req    = req_i[owner_q];
  assign run_end      = (cnt_q == len_q);
  assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign win_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

  // State and datapath registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      abort_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; an owner dropping its request beats completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_found) state_d = ST_RUN;
      ST_RUN: begin
        if (!owner_req)   state_d = ST_IDLE;
        else if (run_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: grant load, counting, done/abort pulses.
  always_comb begin
    grant_d = grant_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    last_d  = last_q;
    done_d  = '0;
    abort_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          last_d  = win_idx;
          len_d   = len_arr[win_idx];
          cnt_d   = '0;
          grant_d = win_onehot;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          grant_d = '0;
          abort_d = owner_onehot;
        end else if (run_end) begin
          grant_d = '0;
          done_d  = owner_onehot;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      ST_DONE: grant_d = '0;
      default: grant_d = '0;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign abort_o = abort_q;
  assign cnt_o   = cnt_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed runs with a scoreboard of expected
// grants and done/abort events, checked by a negedge monitor.
module tb_counter_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int EW    = 1 + NREQ + WIDTH;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_i = '0;
  logic [NREQ*WIDTH-1:0] len_i = '0;
  logic [NREQ-1:0]       grant_o;
  logic [IDX_W-1:0]      owner_o;
  logic                  busy_o;
  logic [WIDTH-1:0]      cnt_o;
  logic [NREQ-1:0]       done_o;
  logic [NREQ-1:0]       abort_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Event entry: {is_abort, one-hot target, cnt_o at the pulse}.
  logic [EW-1:0]    exp_q [$];
  logic [IDX_W-1:0] gnt_q [$];
  logic [NREQ-1:0]  prev_grant = '0;

  counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .len_i   (len_i),
    .grant_o (grant_o),
    .owner_o (owner_o),
    .busy_o  (busy_o),
    .cnt_o   (cnt_o),
    .done_o  (done_o),
    .abort_o (abort_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] k);
    onehot = '0;
    onehot[k] = 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: invariants each cycle, pop expected grants and done/abort events.
  always @(negedge clk) begin
    if (!reset) begin
      check("both_pulses", 32'(done_o & abort_o), 32'd0);
      check("grant_onehot", 32'(grant_o & (grant_o - 1'b1)), 32'd0);
      if ((done_o | abort_o) != '0) begin
        if (exp_q.size() == 0)
          check("unexpected_event", 32'({|abort_o, done_o | abort_o, cnt_o}), 32'd0);
        else
          check("event", 32'({|abort_o, done_o | abort_o, cnt_o}), 32'(exp_q.pop_front()));
      end
      if (prev_grant == '0 && grant_o != '0) begin
        if (gnt_q.size() == 0)
          check("unexpected_grant", 32'(grant_o), 32'd0);
        else begin
          check("grant", 32'({owner_o, grant_o}), 32'({gnt_q[0], onehot(gnt_q[0])}));
          gnt_q.delete(0);
        end
      end
      prev_grant <= grant_o;
    end else begin
      prev_grant <= '0;
    end
  end

  // Driver tasks.
  task automatic do_reset();
    reset = 1'b1;
    req_i = '0;
    len_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_len(input int k, input logic [WIDTH-1:0] v);
    len_i[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_events(input string name, input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if ((done_o | abort_o) != '0) seen++;
    end
    check(name, 32'(seen), 32'(n));
  endtask

  task automatic wait_cnt(input string name, input logic [WIDTH-1:0] v, input int budget);
    logic found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (grant_o != '0 && cnt_o == v) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    int runs;
    logic seen_done;

    // Reset state
    do_reset();
    check("reset_outputs", 32'({grant_o, done_o, abort_o, cnt_o, owner_o, busy_o}), 32'd0);

    // T1: single run, len 3
    set_len(0, 8'd3);
    req_i = 4'b0001;
    gnt_q.push_back(2'd0);
    exp_q.push_back({1'b0, 4'b0001, 8'd3});
    @(negedge clk);
    check("t1_grant", 32'(grant_o), 32'b0001);
    check("t1_cnt0", 32'(cnt_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("t1_cnt", 32'(cnt_o), 32'(i));
    end
    @(negedge clk);
    check("t1_done", 32'(done_o), 32'b0001);
    check("t1_grant_drop", 32'(grant_o), 32'd0);
    check("t1_busy_done", 32'(busy_o), 32'd1);
    req_i = '0;
    @(negedge clk);
    check("t1_busy_low", 32'(busy_o), 32'd0);
    check("t1_done_pulse", 32'(done_o), 32'd0);

    // T2: all request, len 0, rotation 0,1,2,3,0
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      gnt_q.push_back(IDX_W'(i % NREQ));
      exp_q.push_back({1'b0, onehot(IDX_W'(i % NREQ)), 8'd0});
    end
    wait_events("t2_events", 5, 60);
    req_i = '0;
    @(negedge clk);

    // T3: owner 2 aborts at cnt 4
    set_len(2, 8'd10);
    req_i = 4'b0100;
    gnt_q.push_back(2'd2);
    wait_cnt("t3_reach4", 8'd4, 30);
    req_i = '0;
    exp_q.push_back({1'b1, 4'b0100, 8'd4});
    @(negedge clk);
    check("t3_abort", 32'(abort_o), 32'b0100);
    check("t3_no_done", 32'(done_o), 32'd0);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_grant", 32'(grant_o), 32'd0);
    @(negedge clk);
    check("t3_cnt_hold", 32'(cnt_o), 32'd4);

    // T4: len 255, no wrap, 256 run cycles
    set_len(1, 8'd255);
    req_i = 4'b0010;
    gnt_q.push_back(2'd1);
    exp_q.push_back({1'b0, 4'b0010, 8'd255});
    runs = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      if (done_o != '0) seen_done = 1'b1;
      else if (grant_o != '0) runs++;
    end
    check("t4_run_cycles", 32'(runs), 32'd256);
    req_i = '0;
    @(negedge clk);

    // T5: reset mid-run, then priority back at requester 0
    set_len(2, 8'd20);
    req_i = 4'b0100;
    gnt_q.push_back(2'd2);
    wait_cnt("t5_reach5", 8'd5, 40);
    reset = 1'b1;
    req_i = '0;
    #1;
    check("t5_reset_outputs", 32'({grant_o, done_o, abort_o, cnt_o, owner_o, busy_o}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    len_i = '0;
    req_i = 4'b1011;
    gnt_q.push_back(2'd0);
    exp_q.push_back({1'b0, 4'b0001, 8'd0});
    wait_events("t5_events", 1, 20);
    req_i = '0;
    @(negedge clk);

    // T6: len change during run is ignored
    set_len(1, 8'd3);
    req_i = 4'b0010;
    gnt_q.push_back(2'd1);
    exp_q.push_back({1'b0, 4'b0010, 8'd3});
    wait_cnt("t6_reach1", 8'd1, 20);
    set_len(1, 8'd9);
    wait_events("t6_events", 1, 20);
    check("t6_final_cnt", 32'(cnt_o), 32'd3);
    req_i = '0;

    // Final report
    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
